morse_char_decoder: RTL and testbench
=====================================

Name: morse_char_decoder

Overview:
Receive-side character decoder for the Morse datapath. It times the keyed line produced by the transmit path, or an external key, and classifies marks as dot or dash. It collects the symbols of one character and maps them through the International Morse table to a 6-bit character code. The code is delivered to downstream logic in morse_top through a single-entry valid/ready output buffer.

Parameters:
- UNIT_CYCLES, 1000: clock cycles per Morse time unit (dot length); must be ≥ 4.
- CNT_W, 16: width of the mark/space duration counter; must hold 7*UNIT_CYCLES.
- MAX_SYM, 5: maximum symbols per valid character.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; low forces IDLE.
- key_in  in  1  raw key level, 1 = mark (tone on); asynchronous to clk.
- char_code  out  6  decoded character: 0–25 = A–Z, 26–35 = 0–9, 63 = invalid/unknown.
- char_valid  out  1  char_code holds an undelivered character.
- char_ready  in  1  consumer accepts char_code when char_valid is high.
- word_gap  out  1  one-cycle pulse on word-space detection.
- overrun  out  1  sticky: a character was dropped because the buffer was full.

Behaviour:
- Reset (rst_n low, async): all outputs are 0 except char_code = 63. State is IDLE; counter, symbol count, shift register and synchronizer are all cleared.
- key_in passes through a 2-flop synchronizer (key_s). All timing below refers to key_s, which lags key_in by 2 cycles.
- Counter: cnt resets to 0 on every key_s edge, otherwise increments, saturating at all-ones.
- States and transitions:
  - IDLE: wait for key_s = 1, then go to MARK with cnt = 0.
  - MARK, on the key_s falling edge, with the duration measured as cnt+1 cycles:
    - duration < UNIT_CYCLES/2: glitch. Discard it; return to SPACE if sym_cnt > 0, otherwise IDLE.
    - duration < 2*UNIT_CYCLES: dot. Shift 0 into sym_bits.
    - otherwise: dash. Shift 1 into sym_bits.
    - The newest symbol enters at the LSB. sym_cnt increments and saturates at MAX_SYM+1.
    - Go to SPACE.
  - SPACE:
    - key_s rises before cnt reaches 3*UNIT_CYCLES-1: intra-character gap; go to MARK.
    - cnt reaches 3*UNIT_CYCLES-1: letter end; go to EMIT.
  - EMIT (one cycle):
    - Lookup of (sym_cnt, sym_bits) through the International Morse table. sym_cnt > MAX_SYM or an unlisted pattern gives 63.
    - Load the result into the output buffer, clear sym_cnt/sym_bits, go to GAP.
  - GAP:
    - key_s rises: go to MARK.
    - Space reaches 7*UNIT_CYCLES-1 total: pulse word_gap for one cycle, go to IDLE.
    - word_gap fires at most once per gap.
- Output buffer:
  - char_valid rises the cycle after EMIT.
  - A transfer occurs on any cycle with char_valid & char_ready. char_valid then drops next cycle.
  - EMIT while char_valid & !char_ready: the new char is dropped, the buffer is unchanged, and overrun is set.
  - EMIT on the same cycle as a transfer: the new char is loaded, char_valid stays 1, no overrun.
  - char_code holds its value until the next load.
- ena low: the FSM is forced to IDLE and the symbol accumulator is cleared. The output buffer and overrun are retained, and the handshake still operates.
- overrun clears only on reset.

Test Plan:
1. UNIT_CYCLES=4, ready held 1. Key "A": mark 4, space 4, mark 12, space 40 → char_code=0, char_valid high for exactly 1 cycle, word_gap pulse 1 cycle, 28 cycles into the gap.
2. UNIT_CYCLES=4. Key "S O S" with letter gaps of 12 cycles → codes 18, 14, 18 in order; no word_gap between letters.
3. "A" keyed with an inserted 1-cycle mark inside the first space → glitch ignored, code 0. Six dots → code 63. "1" (dot + 4 dashes) → code 27.
4. ready held 0. Key "E" then "T" → char_code stays 4, overrun=1. Pulse ready → valid drops next cycle. Then key "T" with ready=1 → code 19.
5. Assert rst_n low mid-mark during a dash → all outputs go to reset values immediately. After release, key "E" → code 4 with no stale symbols.
6. ena low mid-character, then high, then key "E" → code 4. A previously buffered char is retained while ena is low.

Source files
------------

// File: rtl/morse_char_decoder.sv
// Morse receive decoder: times the synchronised key line, classifies marks as dot/dash,
// maps each completed character through the International Morse table into a one-entry output buffer.
module morse_char_decoder #(
  parameter int unsigned UNIT_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_SYM     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       key_in,
  output logic [5:0] char_code,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       word_gap,
  output logic       overrun
);

  localparam int unsigned        SC_W         = $clog2(MAX_SYM + 2);
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]   LETTER_END   = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WORD_END     = CNT_W'(7 * UNIT_CYCLES - 1);
  localparam logic [CNT_W:0]     GLITCH_LIM   = (CNT_W+1)'(UNIT_CYCLES / 2);
  localparam logic [CNT_W:0]     DASH_LIM     = (CNT_W+1)'(2 * UNIT_CYCLES);
  localparam logic [SC_W-1:0]    SC_SAT       = SC_W'(MAX_SYM + 1);
  localparam logic [5:0]         CODE_INVALID = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_EMIT,
    ST_GAP
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sync;
  logic               r_key_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [SC_W-1:0]    r_sym_cnt;
  logic [MAX_SYM-1:0] r_sym_bits;
  logic               r_word_gap;
  logic [5:0]         r_code;
  logic               r_valid;
  logic               r_overrun;

  logic               w_key_s;
  logic               w_rise;
  logic               w_fall;
  logic [CNT_W:0]     w_dur;
  logic               w_emit;
  logic               w_xfer;
  logic [5:0]         w_code;

  // Symbol pattern has the first-keyed symbol in the MSB of the len-bit field (dot = 0, dash = 1).
  function automatic logic [5:0] f_lookup(input logic [SC_W-1:0] len, input logic [MAX_SYM-1:0] bits);
    logic [7:0] k;
    logic [5:0] code;
    code = CODE_INVALID;
    k    = {3'(len), 5'(bits)};
    if ((32'(len) <= 32'd5) && (32'(len) <= MAX_SYM)) begin
      case (k)
        8'b001_00000: code = 6'd4;
        8'b001_00001: code = 6'd19;
        8'b010_00001: code = 6'd0;
        8'b010_00000: code = 6'd8;
        8'b010_00011: code = 6'd12;
        8'b010_00010: code = 6'd13;
        8'b011_00100: code = 6'd3;
        8'b011_00110: code = 6'd6;
        8'b011_00101: code = 6'd10;
        8'b011_00111: code = 6'd14;
        8'b011_00010: code = 6'd17;
        8'b011_00000: code = 6'd18;
        8'b011_00001: code = 6'd20;
        8'b011_00011: code = 6'd22;
        8'b100_01000: code = 6'd1;
        8'b100_01010: code = 6'd2;
        8'b100_00010: code = 6'd5;
        8'b100_00000: code = 6'd7;
        8'b100_00111: code = 6'd9;
        8'b100_00100: code = 6'd11;
        8'b100_00110: code = 6'd15;
        8'b100_01101: code = 6'd16;
        8'b100_00001: code = 6'd21;
        8'b100_01001: code = 6'd23;
        8'b100_01011: code = 6'd24;
        8'b100_01100: code = 6'd25;
        8'b101_11111: code = 6'd26;
        8'b101_01111: code = 6'd27;
        8'b101_00111: code = 6'd28;
        8'b101_00011: code = 6'd29;
        8'b101_00001: code = 6'd30;
        8'b101_00000: code = 6'd31;
        8'b101_10000: code = 6'd32;
        8'b101_11000: code = 6'd33;
        8'b101_11100: code = 6'd34;
        8'b101_11110: code = 6'd35;
        default:      code = CODE_INVALID;
      endcase
    end
    return code;
  endfunction

  assign w_key_s = r_sync[1];
  assign w_rise  = w_key_s & ~r_key_d;
  assign w_fall  = ~w_key_s & r_key_d;
  assign w_dur   = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_emit  = (r_state == ST_EMIT) & ena;
  assign w_xfer  = r_valid & char_ready;
  assign w_code  = f_lookup(r_sym_cnt, r_sym_bits);

  // Synchroniser, duration counter and symbol-timing FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sync     <= '0;
      r_key_d    <= 1'b0;
      r_cnt      <= '0;
      r_sym_cnt  <= '0;
      r_sym_bits <= '0;
      r_word_gap <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], key_in};
      r_key_d    <= w_key_s;
      r_word_gap <= 1'b0;
      if (w_rise || w_fall) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (!ena) begin
        r_state    <= ST_IDLE;
        r_sym_cnt  <= '0;
        r_sym_bits <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_key_s) begin
              r_state <= ST_MARK;
              r_cnt   <= '0;
            end
          end
          ST_MARK: begin
            if (w_fall) begin
              if (w_dur < GLITCH_LIM) begin
                r_state <= (r_sym_cnt != '0) ? ST_SPACE : ST_IDLE;
              end else begin
                r_sym_bits <= {r_sym_bits[MAX_SYM-2:0], (w_dur >= DASH_LIM)};
                if (r_sym_cnt != SC_SAT) r_sym_cnt <= r_sym_cnt + SC_W'(1);
                r_state <= ST_SPACE;
              end
            end
          end
          // Letter end wins over a rise landing on the same cycle; GAP then picks up the held mark.
          ST_SPACE: begin
            if (r_cnt >= LETTER_END) r_state <= ST_EMIT;
            else if (w_key_s)        r_state <= ST_MARK;
          end
          ST_EMIT: begin
            r_sym_cnt  <= '0;
            r_sym_bits <= '0;
            r_state    <= ST_GAP;
          end
          ST_GAP: begin
            if (w_key_s) begin
              r_state <= ST_MARK;
            end else if (r_cnt >= WORD_END) begin
              r_word_gap <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Single-entry output buffer; a full buffer drops the new character and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= CODE_INVALID;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_emit) begin
        if (r_valid && !char_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_code  <= w_code;
          r_valid <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign char_code  = r_code;
  assign char_valid = r_valid;
  assign word_gap   = r_word_gap;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_morse_char_decoder.sv
// Directed bench for morse_char_decoder with UNIT_CYCLES = 4 and hand-computed expected codes/timing.
module tb_morse_char_decoder;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       key_in;
  logic [5:0] char_code;
  logic       char_valid;
  logic       char_ready;
  logic       word_gap;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wg_cnt   = 0;
  int         rd_idx   = 0;
  logic [5:0] q_code[$];

  morse_char_decoder #(
    .UNIT_CYCLES(U),
    .CNT_W      (16),
    .MAX_SYM    (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .key_in    (key_in),
    .char_code (char_code),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .word_gap  (word_gap),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Record every delivered character and every word_gap cycle.
  always @(posedge clk) begin
    if (rst_n && char_valid && char_ready) q_code.push_back(char_code);
    if (rst_n && word_gap) wg_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_code(input string tag, input logic [31:0] exp);
    if (rd_idx < q_code.size()) begin
      check_eq(tag, 32'(q_code[rd_idx]), exp);
      rd_idx++;
    end else begin
      check_eq(tag, 32'hFFFF_FFFF, exp);
    end
  endtask

  task automatic skip_q();
    rd_idx = q_code.size();
  endtask

  task automatic mark(input int n);
    key_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic space(input int n);
    key_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits[len-1] is keyed first; 1 = dash.
  task automatic letter(input logic [5:0] bits, input int len, input int gap);
    for (int i = len - 1; i >= 0; i--) begin
      mark(bits[i] ? 3 * U : U);
      if (i > 0) space(U);
    end
    space(gap);
  endtask

  initial begin
    int v_first, v_cnt, wg_first, wg_n, wg_base;
    logic [5:0] v_code;

    rst_n      = 1'b0;
    ena        = 1'b1;
    key_in     = 1'b0;
    char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_code", 32'(char_code), 63);
    check_eq("rst_valid", 32'(char_valid), 0);
    check_eq("rst_word_gap", 32'(word_gap), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "A" with exact output timing measured from the last key_in fall.
    mark(U); space(U); mark(3 * U);
    key_in = 1'b0;
    v_first = 0; v_cnt = 0; wg_first = 0; wg_n = 0; v_code = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (char_valid) begin
        v_cnt++;
        if (v_first == 0) begin
          v_first = n;
          v_code  = char_code;
        end
      end
      if (word_gap) begin
        wg_n++;
        if (wg_first == 0) wg_first = n;
      end
    end
    check_eq("A_valid_at", 32'(v_first), 16);
    check_eq("A_code", 32'(v_code), 0);
    check_eq("A_valid_cycles", 32'(v_cnt), 1);
    check_eq("A_word_gap_at", 32'(wg_first), 31);
    check_eq("A_word_gap_cycles", 32'(wg_n), 1);
    expect_code("A_delivered", 0);

    // S O S with exact 3-unit letter gaps.
    wg_base = wg_cnt;
    letter(6'b000000, 3, 3 * U);
    letter(6'b000111, 3, 3 * U);
    letter(6'b000000, 3, 3 * U);
    check_eq("SOS_no_word_gap", 32'(wg_cnt - wg_base), 0);
    space(40);
    check_eq("SOS_word_gap", 32'(wg_cnt - wg_base), 1);
    expect_code("SOS_S1", 18);
    expect_code("SOS_O", 14);
    expect_code("SOS_S2", 18);

    // Glitch inside a space, overlong character, digit, unlisted pattern.
    mark(U); space(2); mark(1); space(2); mark(3 * U); space(40);
    expect_code("glitch_A", 0);
    letter(6'b000000, 6, 40);
    expect_code("six_dots", 63);
    letter(6'b001111, 5, 40);
    expect_code("digit_1", 27);
    letter(6'b000011, 4, 40);
    expect_code("unlisted_4", 63);

    // Backpressure and overrun.
    char_ready = 1'b0;
    skip_q();
    letter(6'b000000, 1, 20);
    check_eq("bp_E_valid", 32'(char_valid), 1);
    check_eq("bp_E_code", 32'(char_code), 4);
    check_eq("bp_no_overrun", 32'(overrun), 0);
    letter(6'b000001, 1, 20);
    check_eq("bp_T_code_kept", 32'(char_code), 4);
    check_eq("bp_T_valid", 32'(char_valid), 1);
    check_eq("bp_overrun", 32'(overrun), 1);
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    check_eq("bp_valid_drop", 32'(char_valid), 0);
    skip_q();
    char_ready = 1'b1;
    letter(6'b000001, 1, 40);
    expect_code("bp_T_after", 19);
    check_eq("bp_overrun_sticky", 32'(overrun), 1);

    // Asynchronous reset in the middle of a dash, after one dot was collected.
    mark(U); space(U);
    key_in = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_code", 32'(char_code), 63);
    check_eq("mid_rst_valid", 32'(char_valid), 0);
    check_eq("mid_rst_overrun", 32'(overrun), 0);
    check_eq("mid_rst_word_gap", 32'(word_gap), 0);
    key_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    skip_q();
    letter(6'b000000, 1, 40);
    expect_code("post_rst_E", 4);

    // Enable dropped mid-character with a buffered char held.
    char_ready = 1'b0;
    skip_q();
    letter(6'b000001, 1, 20);
    check_eq("ena_T_valid", 32'(char_valid), 1);
    check_eq("ena_T_code", 32'(char_code), 19);
    mark(3 * U); space(2);
    ena = 1'b0;
    space(10);
    check_eq("ena_low_valid_kept", 32'(char_valid), 1);
    check_eq("ena_low_code_kept", 32'(char_code), 19);
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    check_eq("ena_low_handshake", 32'(char_valid), 0);
    space(10);
    ena = 1'b1;
    space(U);
    skip_q();
    char_ready = 1'b1;
    letter(6'b000000, 1, 40);
    expect_code("ena_E_clean", 4);
    check_eq("ena_no_overrun", 32'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
